pattern_generator: RTL and testbench



---
 rtl/pattern_generator.sv | 189 ++++++++++++++++++
 tb/tb_pattern_generator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_generator.sv
// Pattern playback engine: host-loaded pattern RAM replayed onto pat_data
// at a programmable word rate for a programmable number of passes.
module pattern_generator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_strobe,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [31:0]           length,
  input  logic [31:0]           clk_div,
  input  logic [31:0]           repeat_count,
  input  logic [DATA_WIDTH-1:0] idle_value,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  ext_trigger_en,
  input  logic                  ext_trigger,
  output logic [DATA_WIDTH-1:0] pat_data,
  output logic                  pat_strobe,
  output logic                  busy,
  output logic                  finished,
  output logic [31:0]           pass_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_PRIME = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [31:0]           div_q, div_d;
  logic [31:0]           rep_q, rep_d;
  logic [31:0]           hold_q, hold_d;
  logic                  wrap_q, wrap_d;
  logic [31:0]           pass_q, pass_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic                  stb_q, stb_d;
  logic                  busy_q, busy_d;
  logic                  fin_q, fin_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  abort;
  logic                  load;
  logic                  done;
  logic [ADDR_WIDTH-1:0] last_new;

  assign abort = stop | ~enable;
  assign load  = (state_q == S_PLAY) && (hold_q == 32'd0);
  assign done  = load && wrap_q &&
                 ((pass_q + 32'd1) == (rep_q + 32'd1));

  // Lengths beyond the RAM depth clamp to the full memory.
  always_comb begin
    if (|length[31:ADDR_WIDTH]) begin
      last_new = '1;
    end else begin
      last_new = length[ADDR_WIDTH-1:0] - A_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    div_d   = div_q;
    rep_d   = rep_q;
    hold_d  = hold_q;
    wrap_d  = wrap_q;
    pass_d  = pass_q;
    pat_d   = idle_value;
    stb_d   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (start) begin
            div_d  = clk_div;
            rep_d  = repeat_count;
            last_d = last_new;
            pass_d = 32'd0;
            hold_d = 32'd0;
            wrap_d = 1'b0;
            if (length == 32'd0) begin
              state_d = S_FIN;
            end else if (ext_trigger_en) begin
              state_d = S_ARMED;
            end else begin
              state_d = S_PRIME;
            end
          end
        end
        S_ARMED: begin
          if (ext_trigger) begin
            state_d = S_PRIME;
          end
        end
        S_PRIME: begin
          ptr_d   = '0;
          hold_d  = 32'd0;
          wrap_d  = 1'b0;
          state_d = S_PLAY;
        end
        S_PLAY: begin
          if (load) begin
            if (wrap_q) begin
              pass_d = pass_q + 32'd1;
            end
            if (done) begin
              state_d = S_FIN;
            end else begin
              pat_d  = rdata_q;
              stb_d  = 1'b1;
              hold_d = div_q;
              wrap_d = (ptr_q == last_q);
              // Prefetch so the next word is ready at the next load.
              ptr_d  = (ptr_q == last_q) ? '0 : ptr_q + A_ONE;
            end
          end else begin
            hold_d = hold_q - 32'd1;
            pat_d  = pat_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_ARMED) ||
             (state_d == S_PRIME) ||
             (state_d == S_PLAY);
    fin_d  = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      div_q   <= 32'd0;
      rep_q   <= 32'd0;
      hold_q  <= 32'd0;
      wrap_q  <= 1'b0;
      pass_q  <= 32'd0;
      pat_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      div_q   <= div_d;
      rep_q   <= rep_d;
      hold_q  <= hold_d;
      wrap_q  <= wrap_d;
      pass_q  <= pass_d;
      pat_q   <= pat_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  // Read-before-write: a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (wr_strobe) begin
      mem[wr_addr] <= wr_data;
    end
    rdata_q <= mem[ptr_d];
  end

  assign pat_data   = pat_q;
  assign pat_strobe = stb_q;
  assign busy       = busy_q;
  assign finished   = fin_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: table of run configurations, random runs
// against a timing formula model, and hand-written corner sequences.
module tb_pattern_generator;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   length;
  logic [31:0]   clk_div;
  logic [31:0]   repeat_count;
  logic [DW-1:0] idle_value;
  logic          enable;
  logic          start;
  logic          stop;
  logic          ext_trigger_en;
  logic          ext_trigger;
  logic [DW-1:0] pat_data;
  logic          pat_strobe;
  logic          busy;
  logic          finished;
  logic [31:0]   pass_count;

  always #5 clk = ~clk;

  pattern_generator #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .length        (length),
    .clk_div       (clk_div),
    .repeat_count  (repeat_count),
    .idle_value    (idle_value),
    .enable        (enable),
    .start         (start),
    .stop          (stop),
    .ext_trigger_en(ext_trigger_en),
    .ext_trigger   (ext_trigger),
    .pat_data      (pat_data),
    .pat_strobe    (pat_strobe),
    .busy          (busy),
    .finished      (finished),
    .pass_count    (pass_count)
  );

  typedef struct {
    int unsigned len;
    int unsigned dv;
    int unsigned rp;
    int          fin_at;
    int unsigned pass;
  } vec_t;

  vec_t        tbl [6];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    logic [31:0] av;
    av        = a;
    wr_strobe = 1'b1;
    wr_addr   = av[AW-1:0];
    wr_data   = d;
    ref_mem[a] = d;
    step();
    wr_strobe = 1'b0;
  endtask

  // Expected outputs c cycles after the start edge come straight from
  // the word-schedule formula: word w at 2 + w*(div+1).
  task automatic run_cfg(input string nm,
                         input int unsigned len,
                         input int unsigned dv,
                         input int unsigned rp,
                         output int fin_c);
    int unsigned L;
    longint      endc;
    longint      w;
    logic [31:0] e_pat;
    logic        e_stb;
    logic        e_busy;
    logic        e_fin;
    logic [31:0] e_pass;
    L = (len > DEPTH) ? DEPTH : len;
    if (L == 0) endc = 1;
    else endc = 2 + longint'(rp + 1) * L * (dv + 1);
    length       = len;
    clk_div      = dv;
    repeat_count = rp;
    start        = 1'b1;
    step();
    start = 1'b0;
    fin_c = -1;
    for (int c = 1; c <= endc + 4 && fin_c < 0; c++) begin
      step();
      e_pat  = idle_value;
      e_stb  = 1'b0;
      e_busy = 1'b1;
      e_fin  = 1'b0;
      e_pass = 32'd0;
      if (c >= endc) begin
        e_busy = 1'b0;
        e_fin  = 1'b1;
        e_pass = (L == 0) ? 32'd0 : rp + 1;
      end else if (c >= 2) begin
        w      = (c - 2) / (dv + 1);
        e_pat  = ref_mem[int'(w % L)];
        e_stb  = ((c - 2) % (dv + 1)) == 0;
        e_pass = 32'(w / L);
      end
      check($sformatf("%s pat c%0d", nm, c), 64'(pat_data), 64'(e_pat));
      check($sformatf("%s stb c%0d", nm, c), 64'(pat_strobe), 64'(e_stb));
      check($sformatf("%s busy c%0d", nm, c), 64'(busy), 64'(e_busy));
      check($sformatf("%s fin c%0d", nm, c), 64'(finished), 64'(e_fin));
      check($sformatf("%s pass c%0d", nm, c), 64'(pass_count), 64'(e_pass));
      if (finished) fin_c = c;
    end
    if (fin_c < 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: finished never rose within %0d cycles",
               nm, endc + 4);
    end
  endtask

  initial begin
    int f;
    int unsigned rl;
    int unsigned rd;
    int unsigned rr;
    wr_strobe      = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    length         = 32'd0;
    clk_div        = 32'd0;
    repeat_count   = 32'd0;
    idle_value     = 32'h5555_5555;
    enable         = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    ext_trigger_en = 1'b0;
    ext_trigger    = 1'b0;

    tbl[0] = '{len: 4,    dv: 0, rp: 0, fin_at: 6,    pass: 1};
    tbl[1] = '{len: 4,    dv: 2, rp: 1, fin_at: 26,   pass: 2};
    tbl[2] = '{len: 0,    dv: 0, rp: 0, fin_at: 1,    pass: 0};
    tbl[3] = '{len: 1,    dv: 0, rp: 2, fin_at: 5,    pass: 3};
    tbl[4] = '{len: 3,    dv: 1, rp: 0, fin_at: 8,    pass: 1};
    tbl[5] = '{len: 2000, dv: 0, rp: 0, fin_at: 1026, pass: 1};

    #1 rst = 1'b0;
    #2;
    check("reset pat", 64'(pat_data), 64'd0);
    check("reset stb", 64'(pat_strobe), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset fin", 64'(finished), 64'd0);
    check("reset pass", 64'(pass_count), 64'd0);
    @(negedge clk) rst = 1'b1;
    step();
    check("idle tracks", 64'(pat_data), 64'h5555_5555);

    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
    for (int i = 0; i < 4; i++) wr(i, 32'hA0 + i);

    for (int i = 0; i < 6; i++) begin
      run_cfg($sformatf("tbl%0d", i), tbl[i].len, tbl[i].dv, tbl[i].rp, f);
      check($sformatf("tbl%0d fin_at", i), 64'(f), 64'(tbl[i].fin_at));
      check($sformatf("tbl%0d passes", i), 64'(pass_count),
            64'(tbl[i].pass));
    end

    for (int it = 0; it < 8; it++) begin
      rl = $urandom_range(0, 12);
      rd = $urandom_range(0, 3);
      rr = $urandom_range(0, 2);
      for (int i = 0; i < int'(rl); i++) wr(i, $urandom);
      idle_value = $urandom;
      run_cfg($sformatf("rnd%0d", it), rl, rd, rr, f);
      check($sformatf("rnd%0d passes", it), 64'(pass_count),
            (rl == 0) ? 64'd0 : 64'(rr + 1));
    end
    idle_value = 32'h5555_5555;
    for (int i = 0; i < 4; i++) wr(i, 32'hA0 + i);

    // External trigger raised ten cycles after start.
    ext_trigger_en = 1'b1;
    length         = 32'd4;
    clk_div        = 32'd0;
    repeat_count   = 32'd0;
    start          = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("armed busy c%0d", c), 64'(busy), 64'd1);
      check($sformatf("armed pat c%0d", c), 64'(pat_data), 64'h5555_5555);
    end
    ext_trigger = 1'b1;
    step();
    ext_trigger = 1'b0;
    step();
    check("trig T+11 stb", 64'(pat_strobe), 64'd0);
    step();
    check("trig T+12 pat", 64'(pat_data), 64'hA0);
    check("trig T+12 stb", 64'(pat_strobe), 64'd1);
    ext_trigger_en = 1'b0;
    enable = 1'b0;
    step();
    enable = 1'b1;
    check("enable abort busy", 64'(busy), 64'd0);
    check("enable abort pat", 64'(pat_data), 64'h5555_5555);

    // Stop while A2 is on the output, then replay from A0.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    check("pre-stop pat", 64'(pat_data), 64'hA2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop pat", 64'(pat_data), 64'h5555_5555);
    check("stop busy", 64'(busy), 64'd0);
    check("stop fin", 64'(finished), 64'd0);
    check("stop stb", 64'(pat_strobe), 64'd0);
    run_cfg("replay", 4, 0, 0, f);
    check("replay fin_at", 64'(f), 64'd6);

    // Simultaneous start and stop must not launch a run.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("start+stop busy", 64'(busy), 64'd0);
    check("start+stop fin", 64'(finished), 64'd0);
    step();
    check("start+stop busy2", 64'(busy), 64'd0);
    check("start+stop stb", 64'(pat_strobe), 64'd0);

    // Asynchronous reset in the middle of playback.
    length       = 32'd4;
    clk_div      = 32'd2;
    repeat_count = 32'd3;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    check("pre-reset busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid reset pat", 64'(pat_data), 64'd0);
    check("mid reset stb", 64'(pat_strobe), 64'd0);
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset fin", 64'(finished), 64'd0);
    check("mid reset pass", 64'(pass_count), 64'd0);
    @(negedge clk) rst = 1'b1;
    step();
    check("post reset busy", 64'(busy), 64'd0);
    check("post reset pat", 64'(pat_data), 64'h5555_5555);
    step();
    check("post reset idle", 64'(busy), 64'd0);
    check("post reset stb", 64'(pat_strobe), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
